mem_responder: RTL and testbench

- Memory-side responder at chip top: the far end of the CPU's memory port.
- Accepts mem_r_en/mem_w_en, mem_addr and mem_w_data from the memory controller; returns mem_r_data after a fixed, parameterised read latency.
- Holds a synchronous word array, zero-initialised by an internal sweep after reset.
- Serves as the on-chip RAM for simulation and FPGA builds.

---
 rtl/mem_responder_pkg.sv | 18 +
 rtl/mem_rd_pipe.sv | 59 +++++
 rtl/mem_responder.sv | 153 +++++++++++++++
 tb/tb_mem_responder.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_responder_pkg.sv
// -----------------------------------------------------------------------------
// mem_responder_pkg
// Shared constants for the on-chip memory responder:
//   MEM_DATA_WIDTH   - word width, mirrors the global DATA_WIDTH define
//   MAX_READ_LATENCY - deepest read delay line the responder supports
//   ST_INIT / ST_RUN - responder FSM state encodings
// -----------------------------------------------------------------------------
package mem_responder_pkg;

  localparam int MEM_DATA_WIDTH   = 16;
  localparam int MAX_READ_LATENCY = 4;

  typedef logic [0:0] state_t;

  localparam logic [0:0] ST_INIT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

endpackage

// File: rtl/mem_rd_pipe.sv
// -----------------------------------------------------------------------------
// mem_rd_pipe
// LATENCY-deep valid/data delay line for read responses, with synchronous
// clear. Data registers only load when the stage feeding them is valid, so
// the output data holds its last value while rsp_valid is low.
// Ports:
//   clk       in   system clock
//   rst       in   synchronous active-high clear (drops in-flight entries)
//   req_valid in   read accepted this cycle
//   req_data  in   data captured for that read
//   rsp_valid out  response valid, LATENCY cycles after req_valid
//   rsp_data  out  response data
// -----------------------------------------------------------------------------
module mem_rd_pipe
  import mem_responder_pkg::*;
#(
  parameter int WIDTH   = MEM_DATA_WIDTH,
  parameter int LATENCY = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  input  logic [WIDTH-1:0] req_data,
  output logic             rsp_valid,
  output logic [WIDTH-1:0] rsp_data
);

  // Out-of-range latencies are clamped into 1..MAX_READ_LATENCY.
  localparam int DEPTH = (LATENCY < 1) ? 1 :
                         (LATENCY > MAX_READ_LATENCY) ? MAX_READ_LATENCY : LATENCY;

  logic [DEPTH-1:0] valid_r;
  logic [WIDTH-1:0] data_r [DEPTH];

  // Shift valid/data one stage per cycle; clear everything on reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_r <= {DEPTH{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        data_r[i] <= {WIDTH{1'b0}};
      end
    end else begin
      valid_r[0] <= req_valid;
      if (req_valid) begin
        data_r[0] <= req_data;
      end
      for (int i = 1; i < DEPTH; i++) begin
        valid_r[i] <= valid_r[i-1];
        if (valid_r[i-1]) begin
          data_r[i] <= data_r[i-1];
        end
      end
    end
  end

  assign rsp_valid = valid_r[DEPTH-1];
  assign rsp_data  = data_r[DEPTH-1];

endmodule

// File: rtl/mem_responder.sv
// -----------------------------------------------------------------------------
// mem_responder
// Memory-side responder: the far end of the CPU memory port and the on-chip
// RAM for simulation/FPGA builds. After reset an internal sweep zeroes every
// word (2^ADDR_BITS cycles); only then is mem_ready raised and requests
// accepted. Reads return after READ_LATENCY cycles, pipelined one per cycle.
// A read and write in the same cycle (always the same address, there is one
// address port) is write-first.
// Ports:
//   clk         in   system clock, rising edge
//   rst         in   synchronous active-high reset
//   mem_r_en    in   read request
//   mem_w_en    in   write request
//   mem_addr    in   word address, only [ADDR_BITS-1:0] used (aliasing)
//   mem_w_data  in   write data
//   mem_r_data  out  read data, holds when mem_r_valid is low
//   mem_r_valid out  one-cycle pulse per accepted read
//   mem_ready   out  requests accepted (init sweep done)
// -----------------------------------------------------------------------------
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int DATA_WIDTH   = MEM_DATA_WIDTH,
  parameter int ADDR_BITS    = 8,
  parameter int READ_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mem_r_en,
  input  logic                  mem_w_en,
  input  logic [DATA_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_w_data,
  output logic [DATA_WIDTH-1:0] mem_r_data,
  output logic                  mem_r_valid,
  output logic                  mem_ready
);

  localparam int DEPTH = 1 << ADDR_BITS;

  logic [DATA_WIDTH-1:0] mem_array_r [DEPTH];

  state_t                state_r;
  logic [ADDR_BITS-1:0]  init_cnt_r;
  logic                  ready_r;

  logic [ADDR_BITS-1:0]  addr_s;
  logic                  we_s;
  logic [ADDR_BITS-1:0]  wa_s;
  logic [DATA_WIDTH-1:0] wd_s;
  logic                  rd_accept_s;
  logic [DATA_WIDTH-1:0] rd_data_s;

  assign addr_s = mem_addr[ADDR_BITS-1:0];

  // Upper address bits are deliberately ignored so addresses alias.
  generate
    if (DATA_WIDTH > ADDR_BITS) begin : g_addr_alias
      logic unused_addr_s;
      assign unused_addr_s = ^mem_addr[DATA_WIDTH-1:ADDR_BITS];
    end
  endgenerate

  // Select the array write port source: zero sweep in INIT, requester in RUN.
  always_comb begin
    we_s = 1'b0;
    wa_s = {ADDR_BITS{1'b0}};
    wd_s = {DATA_WIDTH{1'b0}};
    case (state_r)
      ST_INIT: begin
        we_s = ~rst;
        wa_s = init_cnt_r;
        wd_s = {DATA_WIDTH{1'b0}};
      end
      ST_RUN: begin
        we_s = mem_w_en & ~rst;
        wa_s = addr_s;
        wd_s = mem_w_data;
      end
      default: begin
        we_s = 1'b0;
        wa_s = {ADDR_BITS{1'b0}};
        wd_s = {DATA_WIDTH{1'b0}};
      end
    endcase
  end

  // Read capture: write-first, so a same-cycle write forwards its data.
  always_comb begin
    rd_accept_s = 1'b0;
    rd_data_s   = {DATA_WIDTH{1'b0}};
    if ((state_r == ST_RUN) && mem_r_en && !rst) begin
      rd_accept_s = 1'b1;
      if (mem_w_en) begin
        rd_data_s = mem_w_data;
      end else begin
        rd_data_s = mem_array_r[addr_s];
      end
    end else begin
      rd_accept_s = 1'b0;
      rd_data_s   = {DATA_WIDTH{1'b0}};
    end
  end

  // Word array write port.
  always_ff @(posedge clk) begin
    if (we_s) begin
      mem_array_r[wa_s] <= wd_s;
    end
  end

  // Init sweep / run FSM; mem_ready rises with the entry into RUN.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= ST_INIT;
      init_cnt_r <= {ADDR_BITS{1'b0}};
      ready_r    <= 1'b0;
    end else begin
      case (state_r)
        ST_INIT: begin
          init_cnt_r <= init_cnt_r + ADDR_BITS'(1);
          if (init_cnt_r == {ADDR_BITS{1'b1}}) begin
            state_r <= ST_RUN;
            ready_r <= 1'b1;
          end
        end
        ST_RUN: begin
          state_r <= ST_RUN;
          ready_r <= 1'b1;
        end
        default: begin
          state_r    <= ST_INIT;
          init_cnt_r <= {ADDR_BITS{1'b0}};
          ready_r    <= 1'b0;
        end
      endcase
    end
  end

  assign mem_ready = ready_r;

  mem_rd_pipe #(
    .WIDTH   (DATA_WIDTH),
    .LATENCY (READ_LATENCY)
  ) u_rd_pipe (
    .clk       (clk),
    .rst       (rst),
    .req_valid (rd_accept_s),
    .req_data  (rd_data_s),
    .rsp_valid (mem_r_valid),
    .rsp_data  (mem_r_data)
  );

endmodule

// File: tb/tb_mem_responder.sv
// -----------------------------------------------------------------------------
// tb_mem_responder
// Directed bench driving two responders in parallel (READ_LATENCY 1 and 3)
// from the same request signals, with hand-computed expected values.
// -----------------------------------------------------------------------------
module tb_mem_responder;

  logic        clk;
  logic        rst;
  logic        mem_r_en;
  logic        mem_w_en;
  logic [15:0] mem_addr;
  logic [15:0] mem_w_data;
  logic [15:0] r_data1;
  logic        r_valid1;
  logic        ready1;
  logic [15:0] r_data3;
  logic        r_valid3;
  logic        ready3;

  int vectors;
  int miscompares;

  mem_responder #(.DATA_WIDTH(16), .ADDR_BITS(8), .READ_LATENCY(1)) dut1 (
    .clk(clk), .rst(rst), .mem_r_en(mem_r_en), .mem_w_en(mem_w_en),
    .mem_addr(mem_addr), .mem_w_data(mem_w_data),
    .mem_r_data(r_data1), .mem_r_valid(r_valid1), .mem_ready(ready1));

  mem_responder #(.DATA_WIDTH(16), .ADDR_BITS(8), .READ_LATENCY(3)) dut3 (
    .clk(clk), .rst(rst), .mem_r_en(mem_r_en), .mem_w_en(mem_w_en),
    .mem_addr(mem_addr), .mem_w_data(mem_w_data),
    .mem_r_data(r_data3), .mem_r_valid(r_valid3), .mem_ready(ready3));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    mem_r_en = 1'b0;
    mem_w_en = 1'b0;
  endtask

  task automatic do_write(input logic [15:0] addr, input logic [15:0] data);
    mem_r_en   = 1'b0;
    mem_w_en   = 1'b1;
    mem_addr   = addr;
    mem_w_data = data;
    tick();
    idle();
  endtask

  // Drive one request cycle, then watch both DUTs for 6 cycles.
  task automatic issue(input logic r, input logic w, input logic [15:0] addr,
                       input logic [15:0] data,
                       output int lat1, output logic [15:0] d1, output int n1,
                       output int lat3, output logic [15:0] d3, output int n3);
    lat1 = -1; d1 = 16'h0000; n1 = 0;
    lat3 = -1; d3 = 16'h0000; n3 = 0;
    mem_r_en   = r;
    mem_w_en   = w;
    mem_addr   = addr;
    mem_w_data = data;
    for (int c = 1; c <= 6; c++) begin
      tick();
      if (c == 1) idle();
      if (r_valid1) begin n1++; lat1 = c; d1 = r_data1; end
      if (r_valid3) begin n3++; lat3 = c; d3 = r_data3; end
    end
  endtask

  // Wait (bounded) for both DUTs to report ready; returns edges counted.
  task automatic wait_ready(output int n, output int spurious);
    n = 0;
    spurious = 0;
    while (!ready1 && n < 300) begin
      tick();
      n++;
      if (r_valid1 || r_valid3) spurious++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle();
    mem_addr = 16'h0000;
    mem_w_data = 16'h0000;
    repeat (3) tick();
    vectors++;
    if (ready1 !== 1'b0 || ready3 !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_ready: got %b/%b expected 0/0", ready1, ready3);
    end
    vectors++;
    if (r_valid1 !== 1'b0 || r_valid3 !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_valid: got %b/%b expected 0/0", r_valid1, r_valid3);
    end
    vectors++;
    if (r_data1 !== 16'h0000 || r_data3 !== 16'h0000) begin
      miscompares++;
      $display("FAIL reset_data: got %h/%h expected 0000/0000", r_data1, r_data3);
    end
  endtask

  task automatic test_init_sweep();
    int n;
    int spurious;
    logic [15:0] addrs [4];
    int lat1, n1, lat3, n3;
    logic [15:0] d1, d3;
    addrs[0] = 16'h0000; addrs[1] = 16'h007F; addrs[2] = 16'h00FF; addrs[3] = 16'h0005;
    rst = 1'b0;
    n = 0;
    spurious = 0;
    // Requests during INIT must be ignored.
    while (!ready1 && n < 300) begin
      if (n == 10) begin
        mem_r_en = 1'b1; mem_w_en = 1'b1;
        mem_addr = 16'h0005; mem_w_data = 16'hAAAA;
      end else begin
        idle();
      end
      tick();
      n++;
      if (r_valid1 || r_valid3) spurious++;
    end
    vectors++;
    if (n !== 256) begin
      miscompares++;
      $display("FAIL init_ready_cycles: got %0d expected 256", n);
    end
    vectors++;
    if (ready3 !== 1'b1) begin
      miscompares++;
      $display("FAIL init_ready3: got %b expected 1", ready3);
    end
    vectors++;
    if (spurious !== 0) begin
      miscompares++;
      $display("FAIL init_no_valid: got %0d valid cycles expected 0", spurious);
    end
    for (int i = 0; i < 4; i++) begin
      issue(1'b1, 1'b0, addrs[i], 16'h0000, lat1, d1, n1, lat3, d3, n3);
      vectors++;
      if (lat1 !== 1 || n1 !== 1 || d1 !== 16'h0000) begin
        miscompares++;
        $display("FAIL init_read_l1 addr %h: got lat %0d cnt %0d data %h expected lat 1 cnt 1 data 0000",
                 addrs[i], lat1, n1, d1);
      end
      vectors++;
      if (lat3 !== 3 || n3 !== 1 || d3 !== 16'h0000) begin
        miscompares++;
        $display("FAIL init_read_l3 addr %h: got lat %0d cnt %0d data %h expected lat 3 cnt 1 data 0000",
                 addrs[i], lat3, n3, d3);
      end
    end
  endtask

  task automatic test_write_read();
    int lat1, n1, lat3, n3;
    logic [15:0] d1, d3;
    do_write(16'h0012, 16'hBEEF);
    issue(1'b1, 1'b0, 16'h0012, 16'h0000, lat1, d1, n1, lat3, d3, n3);
    vectors++;
    if (lat1 !== 1 || n1 !== 1 || d1 !== 16'hBEEF) begin
      miscompares++;
      $display("FAIL wr_rd_l1: got lat %0d cnt %0d data %h expected lat 1 cnt 1 data beef", lat1, n1, d1);
    end
    vectors++;
    if (lat3 !== 3 || n3 !== 1 || d3 !== 16'hBEEF) begin
      miscompares++;
      $display("FAIL wr_rd_l3: got lat %0d cnt %0d data %h expected lat 3 cnt 1 data beef", lat3, n3, d3);
    end
  endtask

  task automatic test_collision();
    int lat1, n1, lat3, n3;
    logic [15:0] d1, d3;
    issue(1'b1, 1'b1, 16'h0040, 16'h1234, lat1, d1, n1, lat3, d3, n3);
    vectors++;
    if (lat1 !== 1 || d1 !== 16'h1234 || lat3 !== 3 || d3 !== 16'h1234) begin
      miscompares++;
      $display("FAIL collision_wfirst: got lat %0d/%0d data %h/%h expected lat 1/3 data 1234/1234",
               lat1, lat3, d1, d3);
    end
    issue(1'b1, 1'b0, 16'h0041, 16'h0000, lat1, d1, n1, lat3, d3, n3);
    vectors++;
    if (lat1 !== 1 || d1 !== 16'h0000 || lat3 !== 3 || d3 !== 16'h0000) begin
      miscompares++;
      $display("FAIL collision_neighbour: got lat %0d/%0d data %h/%h expected lat 1/3 data 0000/0000",
               lat1, lat3, d1, d3);
    end
    issue(1'b1, 1'b0, 16'h0040, 16'h0000, lat1, d1, n1, lat3, d3, n3);
    vectors++;
    if (d1 !== 16'h1234 || d3 !== 16'h1234) begin
      miscompares++;
      $display("FAIL collision_stored: got %h/%h expected 1234/1234", d1, d3);
    end
  endtask

  task automatic test_back_to_back();
    logic        v1 [10];
    logic        v3 [10];
    logic [15:0] dd1 [10];
    logic [15:0] dd3 [10];
    logic        ev1, ev3;
    for (int i = 0; i < 4; i++) do_write(16'(i), 16'(i + 1));
    for (int c = 0; c < 10; c++) begin
      if (c < 4) begin
        mem_r_en = 1'b1; mem_w_en = 1'b0; mem_addr = 16'(c);
      end else begin
        idle();
      end
      tick();
      v1[c] = r_valid1; dd1[c] = r_data1;
      v3[c] = r_valid3; dd3[c] = r_data3;
    end
    for (int c = 0; c < 10; c++) begin
      ev1 = (c < 4);
      ev3 = (c >= 2) && (c <= 5);
      vectors++;
      if (v1[c] !== ev1 || (ev1 && dd1[c] !== 16'(c + 1))) begin
        miscompares++;
        $display("FAIL burst_l1 cycle %0d: got valid %b data %h expected valid %b data %h",
                 c, v1[c], dd1[c], ev1, 16'(c + 1));
      end
      vectors++;
      if (v3[c] !== ev3 || (ev3 && dd3[c] !== 16'(c - 1))) begin
        miscompares++;
        $display("FAIL burst_l3 cycle %0d: got valid %b data %h expected valid %b data %h",
                 c, v3[c], dd3[c], ev3, 16'(c - 1));
      end
    end
  endtask

  task automatic test_alias();
    int lat1, n1, lat3, n3;
    logic [15:0] d1, d3;
    do_write(16'h0105, 16'h5555);
    issue(1'b1, 1'b0, 16'h0005, 16'h0000, lat1, d1, n1, lat3, d3, n3);
    vectors++;
    if (lat1 !== 1 || d1 !== 16'h5555 || lat3 !== 3 || d3 !== 16'h5555) begin
      miscompares++;
      $display("FAIL alias: got lat %0d/%0d data %h/%h expected lat 1/3 data 5555/5555",
               lat1, lat3, d1, d3);
    end
  endtask

  task automatic test_reset_mid_read();
    int n;
    int spurious;
    int late3;
    int lat1, n1, lat3, n3;
    logic [15:0] d1, d3;
    late3 = 0;
    mem_r_en = 1'b1; mem_w_en = 1'b0; mem_addr = 16'h0012;
    tick();
    idle();
    rst = 1'b1;
    tick();
    vectors++;
    if (ready1 !== 1'b0 || ready3 !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_mid_ready: got %b/%b expected 0/0", ready1, ready3);
    end
    if (r_valid3) late3++;
    rst = 1'b0;
    wait_ready(n, spurious);
    vectors++;
    if (late3 + spurious !== 0) begin
      miscompares++;
      $display("FAIL rst_mid_dropped: got %0d valid cycles expected 0", late3 + spurious);
    end
    vectors++;
    if (n !== 256) begin
      miscompares++;
      $display("FAIL rst_mid_resweep: got %0d cycles expected 256", n);
    end
    issue(1'b1, 1'b0, 16'h0012, 16'h0000, lat1, d1, n1, lat3, d3, n3);
    vectors++;
    if (lat1 !== 1 || d1 !== 16'h0000 || lat3 !== 3 || d3 !== 16'h0000) begin
      miscompares++;
      $display("FAIL rst_mid_zeroed: got lat %0d/%0d data %h/%h expected lat 1/3 data 0000/0000",
               lat1, lat3, d1, d3);
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    test_reset();
    test_init_sweep();
    test_write_read();
    test_collision();
    test_back_to_back();
    test_alias();
    test_reset_mid_read();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
